// File: rtl/mem_port_arbiter.sv
// Shares one 32-bit memory port between instruction fetch and load/store.
// Round-robin on simultaneous requests, timeout abort of hung accesses.
module mem_port_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        sel,
  output logic        busy,
  output logic        timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic               owner_i;
  logic               last_i;
  logic [CNT_W-1:0]   wait_cnt;
  logic               grant_i;
  logic               grant_d;

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_W'(TIMEOUT)) ? c : c + CNT_W'(1);
  endfunction

  // On a tie the requester not served last wins.
  always_comb begin
    grant_i = i_req & (~d_req | ~last_i);
    grant_d = d_req & ~grant_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner_i     <= 1'b0;
      last_i      <= 1'b0;
      wait_cnt    <= '0;
      sel         <= 1'b0;
      i_rdata     <= '0;
      d_rdata     <= '0;
      i_done      <= 1'b0;
      d_done      <= 1'b0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_i || grant_d) begin
            state    <= BUSY;
            busy     <= 1'b1;
            mem_en   <= 1'b1;
            wait_cnt <= '0;
            owner_i  <= grant_i;
            sel      <= grant_i;
            last_i   <= grant_i;
            if (grant_i) begin
              mem_addr  <= i_addr;
              mem_we    <= 1'b0;
              mem_wdata <= '0;
            end else begin
              mem_addr  <= d_addr;
              mem_we    <= d_we;
              mem_wdata <= d_wdata;
            end
          end
        end

        BUSY: begin
          if (mem_ready || (wait_cnt == CNT_W'(TIMEOUT - 1))) begin
            if (mem_ready) begin
              if (owner_i)      i_rdata <= mem_rdata;
              else if (!mem_we) d_rdata <= mem_rdata;
            end else begin
              // Abort: owner sees zero data and the sticky error flag.
              timeout_err <= 1'b1;
              if (owner_i) i_rdata <= '0;
              else         d_rdata <= '0;
              wait_cnt <= cnt_sat_inc(wait_cnt);
            end
            state     <= DONE;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_done    <= owner_i;
            d_done    <= ~owner_i;
          end else begin
            wait_cnt <= cnt_sat_inc(wait_cnt);
          end
        end

        DONE: begin
          state  <= IDLE;
          busy   <= 1'b0;
          i_done <= 1'b0;
          d_done <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level reference model checked
// every cycle, plus hand-computed expectations per scenario.
module tb_mem_port_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_done;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'hDEAD_BEEF;
  logic        mem_ready = 1'b0;
  logic        sel;
  logic        busy;
  logic        timeout_err;

  int total = 0;
  int bad = 0;

  mem_port_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .sel(sel), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // Memory responder: ready after wait_n stalled cycles of an access.
  int          wait_n = 0;
  logic [31:0] rd_val = 32'h0;
  int          busy_seen = 0;
  always @(negedge clk) begin
    if (mem_en === 1'b1) begin
      if (busy_seen == wait_n) begin
        mem_ready = 1'b1;
        mem_rdata = rd_val;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
      end
      busy_seen++;
    end else begin
      mem_ready = 1'b0;
      mem_rdata = 32'hDEAD_BEEF;
      busy_seen = 0;
    end
  end

  // Reference model: one access at a time, described by who owns it, what
  // it carries, how long it has stalled, and whether its completion is showing.
  bit          m_valid = 0;
  bit          m_last_i, m_active, m_finishing, m_own_i, m_we, m_terr;
  logic [31:0] m_addr, m_wdata, m_i_rdata, m_d_rdata;
  int          m_waited;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_last_i = 0; m_active = 0; m_finishing = 0; m_own_i = 0; m_we = 0; m_terr = 0;
      m_addr = 0; m_wdata = 0; m_i_rdata = 0; m_d_rdata = 0; m_waited = 0;
    end else if (m_finishing) begin
      m_finishing = 0;
    end else if (m_active) begin
      if (mem_ready) begin
        if (m_own_i) m_i_rdata = mem_rdata;
        else if (!m_we) m_d_rdata = mem_rdata;
        m_active = 0; m_finishing = 1;
      end else begin
        m_waited++;
        if (m_waited == TO) begin
          m_terr = 1;
          if (m_own_i) m_i_rdata = 0; else m_d_rdata = 0;
          m_active = 0; m_finishing = 1;
        end
      end
    end else if (i_req || d_req) begin
      m_own_i  = i_req && !(d_req && m_last_i);
      m_last_i = m_own_i;
      m_active = 1;
      m_waited = 0;
      m_addr   = m_own_i ? i_addr : d_addr;
      m_we     = m_own_i ? 1'b0 : d_we;
      m_wdata  = m_own_i ? 32'h0 : d_wdata;
    end
    m_valid = 1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("mem_en",      32'(mem_en),      32'(m_active));
      chk("mem_we",      32'(mem_we),      32'(m_active & m_we));
      chk("mem_addr",    mem_addr,         m_active ? m_addr : 32'h0);
      chk("mem_wdata",   mem_wdata,        m_active ? m_wdata : 32'h0);
      chk("sel",         32'(sel),         32'(m_last_i));
      chk("busy",        32'(busy),        32'(m_active | m_finishing));
      chk("i_done",      32'(i_done),      32'(m_finishing & m_own_i));
      chk("d_done",      32'(d_done),      32'(m_finishing & ~m_own_i));
      chk("i_rdata",     i_rdata,          m_i_rdata);
      chk("d_rdata",     d_rdata,          m_d_rdata);
      chk("timeout_err", 32'(timeout_err), 32'(m_terr));
    end
  end

  task automatic wait_idle();
    bit ok = 0;
    for (int c = 0; c < 40; c++) begin
      if (busy === 1'b0) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    chk("wait_idle_bound", 32'(ok), 32'd1);
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (i_done === 1'b1 || d_done === 1'b1) begin
        ok = 1;
        break;
      end
    end
    chk("wait_done_bound", 32'(ok), 32'd1);
  endtask

  int n_we, n_done, n_busy, ng;
  bit prev_en;
  bit g_sel[4];
  bit g_we[4];
  bit exp_sel[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  bit exp_we[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    rst_n = 0; i_req = 1; d_req = 1; i_addr = 32'h10; d_addr = 32'h20;
    d_we = 0; d_wdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_busy",   32'(busy), 0);
    chk("rst_sel",    32'(sel), 0);
    chk("rst_terr",   32'(timeout_err), 0);
    chk("rst_d_rdata", d_rdata, 0);
    rst_n = 1;
    @(negedge clk);
    chk("first_grant_sel",  32'(sel), 1);
    chk("first_grant_addr", mem_addr, 32'h10);
    i_req = 0; d_req = 0;
    wait_idle();

    // Single fetch
    i_req = 1; i_addr = 32'h40; rd_val = 32'h2008_0005; wait_n = 0;
    @(negedge clk);
    i_req = 0;
    chk("fetch_mem_en",   32'(mem_en), 1);
    chk("fetch_mem_addr", mem_addr, 32'h40);
    @(negedge clk);
    chk("fetch_i_done",   32'(i_done), 1);
    chk("fetch_i_rdata",  i_rdata, 32'h2008_0005);
    chk("fetch_d_done",   32'(d_done), 0);
    chk("fetch_addr_off", mem_addr, 0);
    @(negedge clk);
    chk("fetch_i_done_end", 32'(i_done), 0);
    wait_idle();

    // Load, one stall cycle
    d_req = 1; d_we = 0; d_addr = 32'h300; rd_val = 32'h5555_AAAA; wait_n = 1;
    @(negedge clk);
    d_req = 0;
    wait_done();
    chk("load_d_rdata", d_rdata, 32'h5555_AAAA);
    wait_idle();

    // Store, ready after three stall cycles
    d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hCAFE_F00D;
    rd_val = 32'h9999_9999; wait_n = 3; n_we = 0; n_done = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 0) d_req = 0;
      if (mem_we === 1'b1 && mem_wdata === 32'hCAFE_F00D) n_we++;
      if (d_done === 1'b1) n_done++;
    end
    chk("store_we_cycles", 32'(n_we), 4);
    chk("store_done_cnt",  32'(n_done), 1);
    chk("store_d_rdata",   d_rdata, 32'h5555_AAAA);
    wait_idle();

    // Contention: both requesting continuously, zero-wait memory
    i_req = 1; d_req = 1; i_addr = 32'h80; d_addr = 32'h200; d_we = 1;
    d_wdata = 32'h1111_2222; rd_val = 32'h0BAD_F00D; wait_n = 0;
    ng = 0; prev_en = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      @(negedge clk);
      if (mem_en === 1'b1 && !prev_en) begin
        g_sel[ng] = sel;
        g_we[ng]  = mem_we;
        ng++;
        if (ng == 4) begin
          i_req = 0; d_req = 0;
        end
      end
      prev_en = (mem_en === 1'b1);
    end
    chk("contend_grants", 32'(ng), 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("contend_sel%0d", k), 32'(g_sel[k]), 32'(exp_sel[k]));
      chk($sformatf("contend_we%0d", k),  32'(g_we[k]),  32'(exp_we[k]));
    end
    i_req = 0; d_req = 0;
    wait_idle();
    d_we = 0;

    // Timeout on a load
    d_req = 1; d_addr = 32'h400; wait_n = 1000; n_busy = 0; n_done = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 0) d_req = 0;
      if (mem_en === 1'b1) n_busy++;
      if (d_done === 1'b1) n_done++;
    end
    chk("to_busy_cycles", 32'(n_busy), 4);
    chk("to_done_cnt",    32'(n_done), 1);
    chk("to_d_rdata",     d_rdata, 0);
    chk("to_err",         32'(timeout_err), 1);
    wait_idle();

    // Successful access afterwards keeps the error flag
    i_req = 1; i_addr = 32'h44; rd_val = 32'h7777_0001; wait_n = 0;
    @(negedge clk);
    i_req = 0;
    wait_done();
    chk("post_to_i_rdata", i_rdata, 32'h7777_0001);
    chk("post_to_err",     32'(timeout_err), 1);
    wait_idle();

    // Reset in the second BUSY cycle
    i_req = 1; i_addr = 32'h48; wait_n = 1000;
    @(negedge clk);
    i_req = 0;
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    chk("midrst_busy",   32'(busy), 0);
    chk("midrst_mem_en", 32'(mem_en), 0);
    chk("midrst_err",    32'(timeout_err), 0);
    chk("midrst_i_done", 32'(i_done), 0);
    rst_n = 1;
    n_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (i_done === 1'b1 || d_done === 1'b1) n_done++;
    end
    chk("midrst_no_done", 32'(n_done), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule
